// File: rtl/rl_force_tag_pipe_if.sv
// Port bundle for the range-limited force tag-alignment stage: pair entry, force
// pipeline output and the aligned, tagged force output.
interface rl_force_tag_pipe_if #(
  parameter int DATA_WIDTH        = 32,
  parameter int CELL_ID_WIDTH     = 3,
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int ID_WIDTH          = 3*CELL_ID_WIDTH + PARTICLE_ID_WIDTH,
  parameter int INFLIGHT_WIDTH    = 6
);
  logic                         in_valid;
  logic [ID_WIDTH-1:0]          in_nb_id;
  logic [3*CELL_ID_WIDTH-1:0]   in_ref_cell_id;
  logic [PARTICLE_ID_WIDTH-1:0] in_ref_pid;
  logic                         force_valid;
  logic [DATA_WIDTH-1:0]        force_x;
  logic [DATA_WIDTH-1:0]        force_y;
  logic [DATA_WIDTH-1:0]        force_z;
  logic                         out_valid;
  logic [ID_WIDTH-1:0]          out_ref_id;
  logic [ID_WIDTH-1:0]          out_nb_id;
  logic [DATA_WIDTH-1:0]        out_force_x;
  logic [DATA_WIDTH-1:0]        out_force_y;
  logic [DATA_WIDTH-1:0]        out_force_z;
  logic                         out_ref_first;
  logic [INFLIGHT_WIDTH-1:0]    inflight_count;
  logic                         ref_drained;
  logic                         align_error;

  modport master (
    output in_valid, in_nb_id, in_ref_cell_id, in_ref_pid,
    output force_valid, force_x, force_y, force_z,
    input  out_valid, out_ref_id, out_nb_id, out_force_x, out_force_y, out_force_z,
    input  out_ref_first, inflight_count, ref_drained, align_error
  );

  modport slave (
    input  in_valid, in_nb_id, in_ref_cell_id, in_ref_pid,
    input  force_valid, force_x, force_y, force_z,
    output out_valid, out_ref_id, out_nb_id, out_force_x, out_force_y, out_force_z,
    output out_ref_first, inflight_count, ref_drained, align_error
  );
endinterface

// File: rtl/rl_force_tag_pipe.sv
// Carries pair IDs alongside the force pipeline in a matched-latency tag line and
// emits each force with its IDs, first-of-reference flag, in-flight count and alignment check.
module rl_force_tag_pipe #(
  parameter int DATA_WIDTH        = 32,
  parameter int CELL_ID_WIDTH     = 3,
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int ID_WIDTH          = 3*CELL_ID_WIDTH + PARTICLE_ID_WIDTH,
  parameter int PIPE_LATENCY      = 14,
  parameter int INFLIGHT_WIDTH    = 6
) (
  input logic               clk,
  input logic               rst,
  rl_force_tag_pipe_if.slave bus
);
  localparam int TAG_W = 1 + 2*ID_WIDTH;

  logic [TAG_W-1:0] tag_q [PIPE_LATENCY];
  logic [TAG_W-1:0] tag_d [PIPE_LATENCY];

  logic                      tap_valid;
  logic [ID_WIDTH-1:0]       tap_nb;
  logic [ID_WIDTH-1:0]       tap_ref;

  logic                      out_valid_q, out_valid_d;
  logic [ID_WIDTH-1:0]       out_ref_q, out_ref_d;
  logic [ID_WIDTH-1:0]       out_nb_q, out_nb_d;
  logic [DATA_WIDTH-1:0]     out_fx_q, out_fx_d;
  logic [DATA_WIDTH-1:0]     out_fy_q, out_fy_d;
  logic [DATA_WIDTH-1:0]     out_fz_q, out_fz_d;
  logic                      out_first_q, out_first_d;
  logic [ID_WIDTH-1:0]       last_ref_q, last_ref_d;
  logic                      seen_q, seen_d;
  logic [INFLIGHT_WIDTH-1:0] cnt_q, cnt_d;
  logic                      drained_q, drained_d;
  logic                      err_q, err_d;

  // The ref cell and pid concatenate to exactly the full reference ID.
  assign {tap_valid, tap_nb, tap_ref} = tag_q[PIPE_LATENCY-1];

  always_comb begin
    tag_d[0] = {bus.in_valid, bus.in_nb_id, bus.in_ref_cell_id, bus.in_ref_pid};
    for (int i = 1; i < PIPE_LATENCY; i++) tag_d[i] = tag_q[i-1];
  end

  always_comb begin
    out_valid_d = bus.force_valid;
    out_ref_d   = out_ref_q;
    out_nb_d    = out_nb_q;
    out_fx_d    = out_fx_q;
    out_fy_d    = out_fy_q;
    out_fz_d    = out_fz_q;
    last_ref_d  = last_ref_q;
    seen_d      = seen_q;
    out_first_d = bus.force_valid & (~seen_q | (tap_ref != last_ref_q));
    if (bus.force_valid) begin
      out_ref_d  = tap_ref;
      out_nb_d   = tap_nb;
      out_fx_d   = bus.force_x;
      out_fy_d   = bus.force_y;
      out_fz_d   = bus.force_z;
      last_ref_d = tap_ref;
      seen_d     = 1'b1;
    end

    cnt_d = cnt_q;
    err_d = err_q | (tap_valid != bus.force_valid);
    if (bus.in_valid && !bus.force_valid) begin
      if (&cnt_q) err_d = 1'b1;
      else        cnt_d = cnt_q + INFLIGHT_WIDTH'(1);
    end else if (bus.force_valid && !bus.in_valid) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - INFLIGHT_WIDTH'(1);
    end
    drained_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LATENCY; i++) tag_q[i] <= '0;
      out_valid_q <= 1'b0;
      out_ref_q   <= '0;
      out_nb_q    <= '0;
      out_fx_q    <= '0;
      out_fy_q    <= '0;
      out_fz_q    <= '0;
      out_first_q <= 1'b0;
      last_ref_q  <= '0;
      seen_q      <= 1'b0;
      cnt_q       <= '0;
      drained_q   <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < PIPE_LATENCY; i++) tag_q[i] <= tag_d[i];
      out_valid_q <= out_valid_d;
      out_ref_q   <= out_ref_d;
      out_nb_q    <= out_nb_d;
      out_fx_q    <= out_fx_d;
      out_fy_q    <= out_fy_d;
      out_fz_q    <= out_fz_d;
      out_first_q <= out_first_d;
      last_ref_q  <= last_ref_d;
      seen_q      <= seen_d;
      cnt_q       <= cnt_d;
      drained_q   <= drained_d;
      err_q       <= err_d;
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_ref_id     = out_ref_q;
  assign bus.out_nb_id      = out_nb_q;
  assign bus.out_force_x    = out_fx_q;
  assign bus.out_force_y    = out_fy_q;
  assign bus.out_force_z    = out_fz_q;
  assign bus.out_ref_first  = out_first_q;
  assign bus.inflight_count = cnt_q;
  assign bus.ref_drained    = drained_q;
  assign bus.align_error    = err_q;
endmodule

// File: doc/rl_force_tag_pipe.md
# rl_force_tag_pipe

Parametrised metadata-alignment stage for the range-limited force path. It sits between the filter bank output and the force-writeback/accumulation logic. Each accepted pair's neighbour ID and full reference ID (cell + particle) are tagged at pipeline entry and carried through a delay line whose depth matches the force pipeline latency, so no fixed-delay reference-ID hold is needed. It also counts pairs in flight, flags the first force of each reference particle, and detects valid-alignment errors between the tag line and the force pipeline.

## Interface
- DATA_WIDTH, 32, force component width
- CELL_ID_WIDTH, 3, per-axis cell ID width
- PARTICLE_ID_WIDTH, 7, particle ID width
- ID_WIDTH, 3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH, full particle ID {cell_z, cell_y, cell_x, pid}
- PIPE_LATENCY, 14, cycles from in_valid to matching force_valid; legal range 1..2^INFLIGHT_WIDTH-1
- INFLIGHT_WIDTH, 6, in-flight counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  pair entered force pipeline this cycle
- in_nb_id  in  ID_WIDTH  neighbour particle ID
- in_ref_cell_id  in  3*CELL_ID_WIDTH  reference cell ID {z, y, x}
- in_ref_pid  in  PARTICLE_ID_WIDTH  current reference particle ID, sampled with in_valid
- force_valid  in  1  force pipeline output valid
- force_x/force_y/force_z  in  DATA_WIDTH each  force components
- out_valid  out  1  registered output valid
- out_ref_id  out  ID_WIDTH  reference ID of the emitted force
- out_nb_id  out  ID_WIDTH  neighbour ID of the emitted force
- out_force_x/y/z  out  DATA_WIDTH each  registered force components
- out_ref_first  out  1  with out_valid: out_ref_id differs from the previous emitted out_ref_id, or this is the first emission since reset
- inflight_count  out  INFLIGHT_WIDTH  pairs accepted but not yet emitted by the force pipeline
- ref_drained  out  1  inflight_count == 0
- align_error  out  1  sticky misalignment flag

## Operation
- Tag line: PIPE_LATENCY stages, each holding {valid, nb_id, ref_cell_id, ref_pid}. Stage 0 loads in_valid and the ID inputs every cycle. The stage-(PIPE_LATENCY-1) output is the tap.
- Alignment: force_valid is compared with tap.valid each cycle.
  - Both 1: normal emission.
  - force_valid=1 with tap.valid=0: set align_error. The force is still emitted with the tap ID fields.
  - tap.valid=1 with force_valid=0: set align_error. The tag is dropped and nothing is emitted.
- Output register: out_valid <= force_valid. On force_valid=1, load out_force_*, out_nb_id and out_ref_id = {tap.ref_cell_id, tap.ref_pid}. Otherwise the data outputs hold their previous values.
- First-of-reference tracking:
  - last_ref register plus seen flag. Both update only on emission.
  - out_ref_first <= force_valid & (!seen | tap_ref != last_ref).
- In-flight counter:
  - +1 on in_valid alone; -1 on force_valid alone; unchanged when both or neither are asserted.
  - force_valid with count 0: count stays 0 and align_error is set.
  - Increment at all-ones: count saturates and align_error is set.
- align_error clears only on reset.
- Reset (asynchronous, at any time): all tag valids, tag data, outputs, counter, last_ref, seen and align_error go to 0, except ref_drained, which resets to 1. In-flight tags are discarded. The force pipeline must share rst, so no stale force_valid arrives afterwards.

## Timing
- in_valid at cycle t → tap valid at cycle t+PIPE_LATENCY, aligned with force_valid at t+PIPE_LATENCY → out_valid and data visible from cycle t+PIPE_LATENCY+1.
- Throughput: one pair per cycle with no bubbles. There is no back-pressure; upstream throttling is done by the filter bank.
- inflight_count and ref_drained are registered and reflect events one cycle later.
- A reference particle change at the input needs no gap: the new in_ref_pid is tagged on the first pair of the new reference.

## Test plan
- Single pair (PIPE_LATENCY=14): in_valid at cycle 10 with nb_id=0x0A5 and ref {cell 1,2,3, pid 5}; force_valid at cycle 24 with force_x=0x3F800000 → out_valid at 25 with matching IDs, out_ref_first=1, and inflight_count at 1 for cycles 11–24, 0 from cycle 25.
- Back-to-back stream: 20 consecutive pairs, ref pid 5 for pairs 0–9 and pid 6 for 10–19 → 20 contiguous outputs; out_ref_first high only on outputs 0 and 10; peak inflight_count=14.
- Misalignment: force_valid asserted at t+13 instead of t+14 → align_error rises and stays high; the late tag is dropped; no extra out_valid.
- Underflow: force_valid with no prior in_valid → align_error=1, inflight_count stays 0, and one output is emitted with zero IDs.
- Asynchronous reset mid-stream (7 pairs in flight) → all outputs 0 immediately and ref_drained=1; the first post-reset emission has out_ref_first=1.
- Parameter sweep: PIPE_LATENCY=1 and 31 with INFLIGHT_WIDTH=5 → the latency equation holds and there is no spurious align_error.
